// File: rtl/tangram_pkg.sv
// Shared types and defaults for the tangram pixel generator: piece geometry record,
// RGB444 colour type and the raster origin of the 800x600 visible area.
package tangram_pkg;

    localparam int COORD_W        = 10;
    localparam int IDX_W          = 3;
    localparam int NUM_PIECES_DEF = 7;
    localparam int H_ACT0_DEF     = 217;
    localparam int V_ACT0_DEF     = 28;

    typedef logic [11:0]        rgb444_t;
    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t  x;
        coord_t  y;
        coord_t  w;
        coord_t  h;
        rgb444_t color;
    } piece_t;

    localparam piece_t PIECE_NONE = '0;

endpackage

// File: rtl/tangram_piece_hit.sv
// Combinational containment test of one pixel against one piece rectangle.
// Edge sums are 11 bits wide so a piece running past x/y=1023 never wraps to the left/top.
module tangram_piece_hit
    import tangram_pkg::*;
(
    input  piece_t piece,
    input  coord_t x,
    input  coord_t y,
    output logic   hit
);

    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;
    logic             in_x;
    logic             in_y;

    always_comb begin
        x_end = {1'b0, piece.x} + {1'b0, piece.w};
        y_end = {1'b0, piece.y} + {1'b0, piece.h};
        in_x  = (x >= piece.x) && ({1'b0, x} < x_end);
        in_y  = (y >= piece.y) && ({1'b0, y} < y_end);
        hit   = (piece.w != '0) && (piece.h != '0) && in_x && in_y;
    end

endmodule

// File: rtl/tangram_pixel_gen.sv
// Renders up to NUM_PIECES prioritised rectangles over a background, 2-cycle pipeline
// (RGB and syncs for input cycle n appear at n+2); writes are refused only in the frame-start cycle.
module tangram_pixel_gen
    import tangram_pkg::*;
#(
    parameter int      NUM_PIECES = NUM_PIECES_DEF,
    parameter int      H_ACT0     = H_ACT0_DEF,
    parameter int      V_ACT0     = V_ACT0_DEF,
    parameter rgb444_t BG_COLOR   = 12'h000
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [10:0]        hc,
    input  logic [10:0]        vc,
    input  logic               vidon,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [COORD_W-1:0] wr_w,
    input  logic [COORD_W-1:0] wr_h,
    input  logic [11:0]        wr_color,
    output logic               wr_ready,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_tick
);

    localparam logic [IDX_W:0] NUM_SLOTS = (IDX_W+1)'(NUM_PIECES);

    piece_t shadow [NUM_PIECES];
    piece_t active [NUM_PIECES];
    logic   dirty;

    logic   frame_start;
    logic   wr_take;
    coord_t x_cur;
    coord_t y_cur;

    coord_t  s1_x;
    coord_t  s1_y;
    logic    s1_vidon;
    logic    s1_hsync;
    logic    s1_vsync;

    logic [NUM_PIECES-1:0] hit;
    rgb444_t pix_color;
    rgb444_t rgb_q;
    logic    hsync_q;
    logic    vsync_q;
    logic    tick_q;

    assign frame_start = (hc == '0) && (vc == '0);
    // The commit owns the shadow bank in the frame-start cycle, so writes are held off there.
    assign wr_ready    = clr | ~frame_start;
    assign wr_take     = wr_en && ({1'b0, wr_idx} < NUM_SLOTS);
    assign x_cur       = COORD_W'(hc - 11'(H_ACT0));
    assign y_cur       = COORD_W'(vc - 11'(V_ACT0));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NUM_PIECES; i++) begin
                shadow[i] <= PIECE_NONE;
                active[i] <= PIECE_NONE;
            end
            dirty <= 1'b0;
        end else if (frame_start) begin
            if (dirty) begin
                active <= shadow;
                dirty  <= 1'b0;
            end
        end else if (wr_take) begin
            shadow[wr_idx] <= '{x: wr_x, y: wr_y, w: wr_w, h: wr_h, color: wr_color};
            dirty          <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_PIECES; i++) begin : g_hit
        tangram_piece_hit u_hit (
            .piece (active[i]),
            .x     (s1_x),
            .y     (s1_y),
            .hit   (hit[i])
        );
    end

    // Scan from the highest slot down so the lowest-index hit has the last word.
    always_comb begin
        pix_color = BG_COLOR;
        for (int i = NUM_PIECES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                pix_color = active[i].color;
            end
        end
        if (!s1_vidon) begin
            pix_color = '0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s1_x     <= '0;
            s1_y     <= '0;
            s1_vidon <= 1'b0;
            s1_hsync <= 1'b0;
            s1_vsync <= 1'b0;
            rgb_q    <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            s1_x     <= x_cur;
            s1_y     <= y_cur;
            s1_vidon <= vidon;
            s1_hsync <= hsync_in;
            s1_vsync <= vsync_in;
            rgb_q    <= pix_color;
            hsync_q  <= s1_hsync;
            vsync_q  <= s1_vsync;
            tick_q   <= frame_start;
        end
    end

    assign red        = rgb_q[11:8];
    assign green      = rgb_q[7:4];
    assign blue       = rgb_q[3:0];
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_tangram_pixel_gen.sv
// Directed and randomised raster stimulus for tangram_pixel_gen, each output cycle compared
// against a rectangle-list reference model of the visible 800x600 area.
module tb_tangram_pixel_gen;

    localparam int          NP = 7;
    localparam int          HA = 217;
    localparam int          VA = 28;
    localparam int          HW = 800;
    localparam int          VH = 600;
    localparam logic [11:0] BG = 12'h5A3;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [10:0] hc = '0;
    logic [10:0] vc = '0;
    logic        vidon = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_idx = '0;
    logic [9:0]  wr_x = '0, wr_y = '0, wr_w = '0, wr_h = '0;
    logic [11:0] wr_color = '0;
    logic        wr_ready;
    logic [3:0]  red, green, blue;
    logic        hsync, vsync, frame_tick;

    int checks = 0;
    int errors = 0;

    // Reference model: shadow/active rectangle lists plus the pixel in flight.
    int          sx[NP], sy[NP], sw[NP], sh[NP];
    logic [11:0] sc[NP];
    int          ax[NP], ay[NP], aw[NP], ah[NP];
    logic [11:0] ac[NP];
    bit          dirty;
    logic [11:0] p_rgb;
    logic        p_hs, p_vs;

    tangram_pixel_gen #(
        .NUM_PIECES (NP),
        .H_ACT0     (HA),
        .V_ACT0     (VA),
        .BG_COLOR   (BG)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .hc         (hc),
        .vc         (vc),
        .vidon      (vidon),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_w       (wr_w),
        .wr_h       (wr_h),
        .wr_color   (wr_color),
        .wr_ready   (wr_ready),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] pix(input int h, input int v);
        int x, y;
        if (h < HA || h >= HA + HW || v < VA || v >= VA + VH) return 12'h000;
        x = h - HA;
        y = v - VA;
        for (int i = 0; i < NP; i++) begin
            if (aw[i] != 0 && ah[i] != 0 && x >= ax[i] && x < ax[i] + aw[i] &&
                y >= ay[i] && y < ay[i] + ah[i]) return ac[i];
        end
        return BG;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            sx[i] = 0; sy[i] = 0; sw[i] = 0; sh[i] = 0; sc[i] = '0;
            ax[i] = 0; ay[i] = 0; aw[i] = 0; ah[i] = 0; ac[i] = '0;
        end
        dirty = 0;
        p_rgb = '0;
        p_hs  = 1'b0;
        p_vs  = 1'b0;
    endtask

    // One pixel clock: entered and left at posedge+1.
    task automatic step(input int h, input int v);
        bit          fs;
        logic [11:0] er;
        logic        ehs, evs;
        hc       = 11'(h);
        vc       = 11'(v);
        vidon    = (h >= HA && h < HA + HW && v >= VA && v < VA + VH);
        hsync_in = 1'($urandom);
        vsync_in = 1'($urandom);
        fs       = (h == 0 && v == 0);
        #1;
        chk("wr_ready", 32'(wr_ready), 32'(!fs));
        @(posedge clk);
        er  = p_rgb;
        ehs = p_hs;
        evs = p_vs;
        if (wr_en && !fs && int'(wr_idx) < NP) begin
            sx[wr_idx] = int'(wr_x); sy[wr_idx] = int'(wr_y);
            sw[wr_idx] = int'(wr_w); sh[wr_idx] = int'(wr_h);
            sc[wr_idx] = wr_color;
            dirty = 1;
        end
        if (fs && dirty) begin
            ax = sx; ay = sy; aw = sw; ah = sh; ac = sc;
            dirty = 0;
        end
        p_rgb = pix(h, v);
        p_hs  = hsync_in;
        p_vs  = vsync_in;
        #1;
        chk("rgb", 32'({red, green, blue}), 32'(er));
        chk("hsync", 32'(hsync), 32'(ehs));
        chk("vsync", 32'(vsync), 32'(evs));
        chk("frame_tick", 32'(frame_tick), 32'(fs));
    endtask

    task automatic scan(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) step(h, v);
    endtask

    task automatic write_piece(input int idx, input int x, input int y, input int w, input int h,
                               input logic [11:0] c, input int hp, input int vp);
        wr_en = 1'b1; wr_idx = 3'(idx);
        wr_x = 10'(x); wr_y = 10'(y); wr_w = 10'(w); wr_h = 10'(h); wr_color = c;
        step(hp, vp);
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        #2 clr = 1'b1;
        #1;
        chk("rst_rgb", 32'({red, green, blue}), 32'h0);
        chk("rst_syncs", 32'({hsync, vsync}), 32'h0);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        chk("rst_wr_ready", 32'(wr_ready), 32'h1);
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        model_reset();
    endtask

    initial begin
        int k, v0, h0;
        model_reset();
        do_reset();

        // Free-running frame, no pieces: background inside vidon, zero outside.
        step(0, 0);
        scan(27, 214, 222);
        scan(28, 212, 225);
        scan(300, 1010, 1020);
        scan(627, 1012, 1019);
        scan(628, 214, 222);

        // Mid-frame write stays invisible until the next frame start.
        write_piece(0, 100, 50, 20, 10, 12'hF00, 500, 300);
        scan(78, 312, 340);
        step(0, 0);
        scan(77, 314, 340);
        scan(78, 312, 340);
        scan(87, 312, 340);
        scan(88, 314, 340);

        // Overlap: lower index wins until slot 0 is disabled.
        write_piece(3, 110, 55, 20, 10, 12'h0F0, 400, 200);
        step(0, 0);
        scan(83, 320, 352);
        write_piece(0, 100, 50, 0, 10, 12'hF00, 400, 201);
        scan(83, 320, 352);
        step(0, 0);
        scan(83, 320, 352);

        // Write held across frame start: refused there, taken next cycle, shown a frame later.
        wr_en = 1'b1; wr_idx = 3'd1;
        wr_x = 10'd200; wr_y = 10'd100; wr_w = 10'd30; wr_h = 10'd20; wr_color = 12'h00F;
        step(0, 0);
        step(1, 0);
        wr_en = 1'b0;
        scan(130, 410, 452);
        step(0, 0);
        scan(130, 410, 452);

        // Out-of-range slot is ignored.
        write_piece(7, 0, 0, 800, 600, 12'hFFF, 600, 300);
        step(0, 0);
        scan(130, 410, 420);
        scan(40, 220, 230);

        // Piece running off the right edge: no wrap into the left columns.
        write_piece(2, 790, 0, 100, 5, 12'h0FF, 700, 400);
        step(0, 0);
        scan(28, 214, 232);
        scan(28, 1000, 1020);
        scan(32, 1003, 1020);
        scan(33, 1003, 1020);

        // Reset mid-line clears pieces; rendering resumes with background.
        scan(30, 1005, 1010);
        do_reset();
        scan(30, 1011, 1020);
        step(0, 0);
        scan(28, 1000, 1020);
        scan(83, 320, 340);

        // Randomised writes, frame starts and line fragments.
        repeat (60) begin
            k = int'($urandom_range(0, 3));
            if (k == 0) begin
                step(0, 0);
            end else if (k == 1) begin
                write_piece(int'($urandom_range(0, 7)), int'($urandom_range(0, 1023)),
                            int'($urandom_range(0, 620)), int'($urandom_range(0, 300)),
                            int'($urandom_range(0, 300)), 12'($urandom),
                            int'($urandom_range(0, 1039)), int'($urandom_range(0, 665)));
            end else begin
                v0 = int'($urandom_range(20, 640));
                h0 = int'($urandom_range(200, 1015));
                scan(v0, h0, h0 + 24);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
